uno_post_scale: RTL and testbench
=================================

# uno_post_scale

Pipelined post-scaling stage of the RAVEN PE that sits directly downstream of the scale generator. It takes the accumulated Taylor-series result of a unary op together with the registered scale factor, then applies mode-dependent multiplication, rounding and saturation. It emits a MUL_BW result over a valid/ready handshake and counts saturation events for debug.

## Interface
- MUL_BW, 16, width of scale input and result
- ACC_BW, 24, width of accumulated input (signed, FRA_BW fraction bits)
- FRA_BW, 10, fraction bits of acc, scale and result
- CNT_BW, 8, width of saturation counter

- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- in_valid  in  1  acc_i/scale_i/gemm_uno valid
- in_ready  out  1  stage can accept input
- gemm_uno  in  2  00 gemm, 01 div, 10 exp, 11 log
- acc_i  in  ACC_BW  signed accumulated result
- scale_i  in  MUL_BW  signed scale (registered scale generator output)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- res_o  out  MUL_BW  signed scaled result
- sat_o  out  1  res_o was saturated
- sat_cnt_o  out  CNT_BW  saturating count of saturated results
- sat_clr  in  1  synchronous clear of sat_cnt_o

## Operation
- Input handshake: transfer when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
- Stage S1 (multiply) registers: mode, p = acc_i * scale_i (signed, ACC_BW+MUL_BW bits), and acc_i.
- Stage S2 (normalize) computes r from S1 by mode:
  - 00 gemm: r = acc (scale ignored).
  - 01 div, 10 exp: r = (p + 2^(FRA_BW-1)) >>> FRA_BW (round half toward +inf, arithmetic shift).
  - 11 log: r = p, with no shift (scale is an integer sign factor, nominally -1).
- Saturation: r is clamped to [-2^(MUL_BW-1), 2^(MUL_BW-1)-1]. sat_o = 1 iff clamped. Registered together with res_o.
- sat_cnt_o increments by 1 on each output transfer with sat_o=1 and holds at 2^CNT_BW-1.
- sat_clr has priority over increment: the counter is 0 next cycle.
- Pipeline control: each stage holds a valid bit.
  - S2 loads when S2 is empty or its output transfers.
  - S1 loads when S1 is empty or S1 moves to S2.
  - in_ready = ~s1_valid | s1_advance. This is a combinational ready; no bubbles under continuous flow.
- Data registers of an invalid stage are don't-care; out_valid must never assert on stale data.

## Timing
- Reset (rst_n=0 at clk edge):
  - Stage valid bits, out_valid, sat_o and sat_cnt_o are cleared to 0. res_o is cleared to 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight results with no output transfer.
- Latency: input accepted at edge N, so out_valid=1 after edge N+1 with the result (2 register stages).
- Throughput: 1 result/cycle when out_ready is held high.
- Backpressure: with out_ready=0, at most 2 inputs are accepted, then in_ready=0. Outputs hold stable while out_valid && ~out_ready.
- Simultaneous output transfer and input transfer in the same cycle on a full pipe: both occur; nothing is lost or duplicated.
- Mode is carried per-transaction through the pipe. A mode change between back-to-back inputs needs no flush.

## Test plan
- Div/exp arithmetic:
  - mode 01, acc=2048, scale=512 -> res=1024, sat=0, 2 cycles after accept.
  - mode 10, acc=1536, scale=2048 -> res=3072.
- Rounding:
  - mode 01, acc=3, scale=512 -> res=2.
  - acc=-3, scale=512 -> res=-1.
- Log/gemm and saturation:
  - mode 11, acc=300, scale=-1 -> res=-300.
  - mode 00, acc=-40000 -> res=-32768, sat=1.
  - mode 10, acc=40000, scale=2048 -> res=32767, sat=1, sat_cnt increments.
- Backpressure: out_ready=0, drive 4 back-to-back inputs.
  - Exactly 2 are accepted, then in_ready=0.
  - Release out_ready: all results emerge in order, none dropped or duplicated, outputs stable while stalled.
- Counter:
  - 260 saturating results with CNT_BW=8 -> sat_cnt_o=255.
  - sat_clr asserted in the same cycle as a saturating transfer -> sat_cnt_o=0.
- Reset mid-flight: rst_n=0 with 2 results pending -> out_valid=0, sat_cnt_o=0, in_ready=1 after reset. No spurious output afterwards.

Source files
------------

// File: rtl/uno_post_scale.sv
// uno_post_scale: multiplies the accumulated Taylor-series result by the scale
// factor, then rounds, normalizes and saturates the product according to the unary-op mode.
// Latency: 2 register stages. An input accepted at edge N is presented on res_o after edge N+1.
// Backpressure: in_ready is combinational (~s1_valid | s1_advance). Under a stall the
// pipe holds two results and stays bubble-free under continuous flow.
module uno_post_scale #(
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 24,
  parameter int FRA_BW = 10,
  parameter int CNT_BW = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               gemm_uno,
  input  logic signed [ACC_BW-1:0] acc_i,
  input  logic signed [MUL_BW-1:0] scale_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [MUL_BW-1:0] res_o,
  output logic                     sat_o,
  output logic [CNT_BW-1:0]        sat_cnt_o,
  input  logic                     sat_clr
);

  // Full-precision product width and one guard bit for the rounding add.
  localparam int P_BW = ACC_BW + MUL_BW;
  localparam int R_BW = P_BW + 1;

  // Rounding constant: half an LSB of the result, 2^(FRA_BW-1).
  localparam logic signed [R_BW-1:0] RND_HALF =
    {{(R_BW-FRA_BW){1'b0}}, 1'b1, {(FRA_BW-1){1'b0}}};

  // Result clamp limits expressed at the wide width.
  localparam logic signed [R_BW-1:0] SAT_MAX =
    {{(R_BW-MUL_BW+1){1'b0}}, {(MUL_BW-1){1'b1}}};
  localparam logic signed [R_BW-1:0] SAT_MIN =
    {{(R_BW-MUL_BW+1){1'b1}}, {(MUL_BW-1){1'b0}}};

  localparam logic [1:0] MODE_GEMM = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_EXP  = 2'b10;

  localparam logic [CNT_BW-1:0] CNT_MAX = {CNT_BW{1'b1}};

  // Stage S1 state (multiply).
  logic                     s1_valid;
  logic [1:0]               s1_mode;
  logic signed [P_BW-1:0]   s1_p;
  logic signed [ACC_BW-1:0] s1_acc;

  // Handshake and flow-control terms.
  logic s2_load;
  logic s1_advance;
  logic in_fire;
  logic out_fire;

  // Product operands sign-extended to the full product width.
  logic signed [P_BW-1:0] acc_x;
  logic signed [P_BW-1:0] scl_x;
  logic signed [P_BW-1:0] prod;

  // Stage S2 combinational normalize and saturate.
  logic signed [R_BW-1:0]   r_wide;
  logic signed [MUL_BW-1:0] res_n;
  logic                     sat_n;

  // S2 (the output register) can take new data when it is empty or is being drained.
  assign out_fire   = out_valid & out_ready;
  assign s2_load    = ~out_valid | out_ready;
  assign s1_advance = s1_valid & s2_load;
  assign in_ready   = ~s1_valid | s1_advance;
  assign in_fire    = in_valid & in_ready;

  assign acc_x = P_BW'(acc_i);
  assign scl_x = P_BW'(scale_i);
  assign prod  = acc_x * scl_x;

  // S1: capture mode, the signed product and the raw accumulator for gemm passthrough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_GEMM;
      s1_p     <= '0;
      s1_acc   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_mode <= gemm_uno;
        s1_p    <= prod;
        s1_acc  <= acc_i;
      end
    end
  end

  // Mode-dependent normalize: gemm passes acc, div/exp round half-up and drop the
  // fraction bits, log uses the raw product because its scale is an integer sign factor.
  always_comb begin
    r_wide = R_BW'(s1_p);
    case (s1_mode)
      MODE_GEMM: r_wide = R_BW'(s1_acc);
      MODE_DIV,
      MODE_EXP:  r_wide = (R_BW'(s1_p) + RND_HALF) >>> FRA_BW;
      default:   r_wide = R_BW'(s1_p);
    endcase
  end

  // Clamp the wide result into the signed MUL_BW range and flag any clamping.
  always_comb begin
    res_n = r_wide[MUL_BW-1:0];
    sat_n = 1'b0;
    if (r_wide > SAT_MAX) begin
      res_n = SAT_MAX[MUL_BW-1:0];
      sat_n = 1'b1;
    end else if (r_wide < SAT_MIN) begin
      res_n = SAT_MIN[MUL_BW-1:0];
      sat_n = 1'b1;
    end
  end

  // S2: output register. It holds steady while stalled and only loads data for a valid S1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_o     <= '0;
      sat_o     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res_o <= res_n;
        sat_o <= sat_n;
      end
    end
  end

  // Debug counter of saturated results actually handed downstream. Clear wins over count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt_o <= '0;
    end else if (sat_clr) begin
      sat_cnt_o <= '0;
    end else if (out_fire && sat_o && (sat_cnt_o != CNT_MAX)) begin
      sat_cnt_o <= sat_cnt_o + CNT_BW'(1);
    end
  end

endmodule

// File: tb/tb_uno_post_scale.sv
module tb_uno_post_scale;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         gemm_uno;
  logic signed [23:0] acc_i;
  logic signed [15:0] scale_i;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] res_o;
  logic               sat_o;
  logic [7:0]         sat_cnt_o;
  logic               sat_clr;

  typedef struct {
    int   res;
    logic sat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   cyc   = 0;

  logic               held_vld = 1'b0;
  logic signed [15:0] held_res;
  logic               held_sat;

  uno_post_scale #(
    .MUL_BW(16), .ACC_BW(24), .FRA_BW(10), .CNT_BW(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gemm_uno  (gemm_uno),
    .acc_i     (acc_i),
    .scale_i   (scale_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_o     (res_o),
    .sat_o     (sat_o),
    .sat_cnt_o (sat_cnt_o),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld && out_valid) begin
        chk("stall_res", longint'(res_o), longint'(held_res));
        chk("stall_sat", longint'(sat_o), longint'(held_sat));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: got res %0d expected no output", res_o);
        end else begin
          e = sb.pop_front();
          chk("res", longint'(res_o), longint'(e.res));
          chk("sat", longint'(sat_o), longint'(e.sat));
          n_out++;
        end
      end
      held_vld = out_valid && !out_ready;
      held_res = res_o;
      held_sat = sat_o;
    end
  end

  // Present one input and wait until it is accepted. Leaves in_valid high for streaming.
  task automatic send(input int mode, input int acc, input int scl,
                      input bit push, input int eres, input bit esat);
    exp_t e;
    int   t;
    in_valid = 1'b1;
    gemm_uno = 2'(mode);
    acc_i    = 24'(acc);
    scale_i  = 16'(scl);
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got in_ready 0 expected 1");
        break;
      end
    end
    if (push) begin
      e.res = eres;
      e.sat = esat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk("drain_empty", longint'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int outs0;
    int accepted;
    bit acc_now;
    int bp_acc[4];
    bp_acc = '{100, 200, -300, 400};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    gemm_uno  = 2'b00;
    acc_i     = '0;
    scale_i   = '0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_sat_cnt", longint'(sat_cnt_o), 0);
    chk("rst_res", longint'(res_o), 0);
    chk("rst_sat", longint'(sat_o), 0);

    // Latency: div 2048*512 -> 1024, visible after the second edge
    send(1, 2048, 512, 1, 1024, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_s1_only", longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_out_valid", longint'(out_valid), 1);
    @(posedge clk);
    #1;

    // Streamed vectors with mode changes: one accept per cycle
    t0 = cyc;
    send(2, 1536, 2048, 1, 3072, 0);
    send(1, 3, 512, 1, 2, 0);
    send(1, -3, 512, 1, -1, 0);
    send(3, 300, -1, 1, -300, 0);
    send(0, -40000, 0, 1, -32768, 1);
    send(2, 40000, 2048, 1, 32767, 1);
    in_valid = 1'b0;
    chk("throughput_cycles", longint'(cyc - t0), 6);
    drain();
    chk("sat_cnt_two", longint'(sat_cnt_o), 2);

    // Backpressure: 4 vectors offered with out_ready low; only 2 fit
    out_ready = 1'b0;
    outs0 = n_out;
    accepted = 0;
    in_valid = 1'b1;
    gemm_uno = 2'b01;
    scale_i  = 16'sd1024;
    acc_i    = 24'(bp_acc[0]);
    for (int c = 0; c < 8; c++) begin
      exp_t e;
      @(negedge clk);
      acc_now = in_ready && in_valid;
      if (acc_now) begin
        e.res = bp_acc[accepted];
        e.sat = 1'b0;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        accepted++;
        if (accepted < 4) acc_i = 24'(bp_acc[accepted]);
        else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", longint'(accepted), 2);
    chk("bp_in_ready", longint'(in_ready), 0);
    chk("bp_out_valid", longint'(out_valid), 1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && accepted < 4; c++) begin
      exp_t e;
      @(negedge clk);
      acc_now = in_ready && in_valid;
      if (acc_now) begin
        e.res = bp_acc[accepted];
        e.sat = 1'b0;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        accepted++;
        if (accepted < 4) acc_i = 24'(bp_acc[accepted]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    drain();
    chk("bp_out_count", longint'(n_out - outs0), 4);

    // Counter saturates at 255 after 260 more saturating results
    for (int i = 0; i < 260; i++) send(0, 40000, 0, 1, 32767, 1);
    in_valid = 1'b0;
    drain();
    chk("sat_cnt_hold", longint'(sat_cnt_o), 255);

    // sat_clr in the same cycle as a saturating transfer wins
    send(0, 40000, 0, 1, 32767, 1);
    in_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("sat_clr_priority", longint'(sat_cnt_o), 0);
    send(2, -40000, 2048, 1, -32768, 1);
    in_valid = 1'b0;
    drain();
    chk("sat_cnt_after_clr", longint'(sat_cnt_o), 1);

    // Reset mid-flight with two results pending
    out_ready = 1'b0;
    send(1, 2048, 512, 0, 0, 0);
    send(0, -40000, 0, 0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pending", longint'(out_valid), 1);
    chk("mid_full", longint'(in_ready), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_sat_cnt", longint'(sat_cnt_o), 0);
    chk("mid_rst_in_ready", longint'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_no_spurious", longint'(out_valid), 0);
    end

    chk("sb_final_empty", longint'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
